// File: rtl/uart_pkg.sv
// Shared UART types and constants used by the receive path and the sender side.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    localparam int UART_CLKS_PER_BIT_DEFAULT = 868;
    localparam int UART_DATA_BITS            = 8;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// One-bit two-flop synchronizer for an asynchronous input; reset value is a parameter.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule : sync_2ff

// File: rtl/uart_rx_fsm.sv
// 8N1 UART byte receiver: start-bit validation, mid-bit sampling, framing-error pulse.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       UART_RX,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic rx_s;
    logic rx_prev_reg;

    rx_state_t                 state_reg,     state_next;
    logic [CNT_W-1:0]          cnt_reg,       cnt_next;
    logic [2:0]                bit_idx_reg,   bit_idx_next;
    logic [UART_DATA_BITS-1:0] shreg_reg,     shreg_next;
    logic [7:0]                data_reg,      data_next;
    logic                      valid_reg,     valid_next;
    logic                      frame_err_reg, frame_err_next;

    sync_2ff #(
        .RESET_VAL (1'b0)
    ) u_sync (
        .clk  (CLK),
        .srst (RST),
        .d    (UART_RX),
        .q    (rx_s)
    );

    // Resetting rx_prev low means neither a held-low nor a high line at release looks like an edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_prev_reg   <= 1'b0;
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            shreg_reg     <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            rx_prev_reg   <= rx_s;
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shreg_reg     <= shreg_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg + 1'b1;
        bit_idx_next   = bit_idx_reg;
        shreg_next     = shreg_reg;
        data_next      = data_reg;
        valid_next     = 1'b0;
        frame_err_next = 1'b0;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (rx_prev_reg && !rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                // Still low at mid-start-bit means a real start; otherwise treat as a glitch.
                if (cnt_reg == CNT_HALF) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next     = '0;
                    shreg_next   = {rx_s, shreg_reg[UART_DATA_BITS-1:1]};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == LAST_BIT) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                // Returning to IDLE at mid-stop-bit leaves half a bit of slack for baud mismatch.
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (rx_s) begin
                        data_next  = shreg_reg;
                        valid_next = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign data      = data_reg;
    assign valid     = valid_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg != IDLE);

endmodule : uart_rx_fsm

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm at 16 clocks per bit (clock period 10 time units).
module tb_uart_rx_fsm;

    localparam int CPB    = 16;
    localparam int BIT_NS = CPB * 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    int cyc       = 0;
    int ferr_cnt  = 0;
    int busy_cnt  = 0;
    int both_cnt  = 0;
    int start_cyc = 0;
    int vq_cyc[$];
    logic [7:0] vq_data[$];

    uart_rx_fsm #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .UART_RX   (uart_rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            vq_cyc.push_back(cyc);
            vq_data.push_back(data);
            $display("valid  cyc=%0d data=%02h", cyc, data);
        end
        if (frame_err) begin
            ferr_cnt <= ferr_cnt + 1;
            $display("ferr   cyc=%0d", cyc);
        end
        if (busy) busy_cnt <= busy_cnt + 1;
        if (valid && frame_err) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offset drives 2 units past a falling clock edge so line changes never coincide with a rising edge.
    task automatic align();
        @(negedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b, input int bit_ns, input logic stop_val);
        start_cyc = cyc;
        uart_rx = 1'b0;
        #(bit_ns);
        for (int k = 0; k < 8; k++) begin
            uart_rx = b[k];
            #(bit_ns);
        end
        uart_rx = stop_val;
        #(bit_ns);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int v0, f0, b0, first_start;

    initial begin
        // Reset
        idle(4);
        chk("rst_data", data, 8'h00);
        chk("rst_valid", valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        idle(10);
        chk("release_busy", busy, 0);

        // Clean byte 0x55 with exact valid timing
        v0 = vq_cyc.size(); f0 = ferr_cnt;
        align();
        send_byte(8'h55, BIT_NS, 1'b1);
        idle(20);
        chk("clean_count", vq_cyc.size() - v0, 1);
        if (vq_cyc.size() == v0 + 1) begin
            chk("clean_data", vq_data[v0], 8'h55);
            chk("clean_time", vq_cyc[v0] - start_cyc, 155);
        end
        chk("clean_ferr", ferr_cnt - f0, 0);

        // Back-to-back 0xA3, 0x0F
        v0 = vq_cyc.size();
        align();
        first_start = cyc;
        send_byte(8'hA3, BIT_NS, 1'b1);
        send_byte(8'h0F, BIT_NS, 1'b1);
        idle(20);
        chk("b2b_count", vq_cyc.size() - v0, 2);
        if (vq_cyc.size() == v0 + 2) begin
            chk("b2b_data0", vq_data[v0], 8'hA3);
            chk("b2b_data1", vq_data[v0+1], 8'h0F);
            chk("b2b_gap", vq_cyc[v0+1] - vq_cyc[v0], 160);
            chk("b2b_time0", vq_cyc[v0] - first_start, 155);
        end

        // False start: 3-cycle glitch
        v0 = vq_cyc.size(); f0 = ferr_cnt; b0 = busy_cnt;
        align();
        uart_rx = 1'b0;
        #30;
        uart_rx = 1'b1;
        idle(40);
        chk("glitch_busy_cycles", busy_cnt - b0, 8);
        chk("glitch_valid", vq_cyc.size() - v0, 0);
        chk("glitch_ferr", ferr_cnt - f0, 0);
        chk("glitch_data", data, 8'h0F);
        chk("glitch_idle", busy, 0);

        // Framing error, then a held-low break, then a good 0x12
        v0 = vq_cyc.size(); f0 = ferr_cnt;
        align();
        send_byte(8'hC6, BIT_NS, 1'b0);
        idle(400);
        chk("ferr_count", ferr_cnt - f0, 1);
        chk("ferr_valid", vq_cyc.size() - v0, 0);
        chk("ferr_data", data, 8'h0F);
        chk("break_idle", busy, 0);
        uart_rx = 1'b1;
        idle(40);
        align();
        send_byte(8'h12, BIT_NS, 1'b1);
        idle(20);
        chk("after_break_count", vq_cyc.size() - v0, 1);
        if (vq_cyc.size() == v0 + 1) chk("after_break_data", vq_data[v0], 8'h12);
        chk("after_break_ferr", ferr_cnt - f0, 1);

        // Reset during data bit 4 of 0x81
        v0 = vq_cyc.size(); f0 = ferr_cnt;
        align();
        uart_rx = 1'b0;
        #(BIT_NS);
        for (int k = 0; k < 4; k++) begin
            uart_rx = k[0] ? 1'b0 : (k == 0);
            #(BIT_NS);
        end
        uart_rx = 1'b0;
        #(BIT_NS / 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_data", data, 8'h00);
        chk("midrst_valid", valid, 0);
        chk("midrst_ferr", frame_err, 0);
        chk("midrst_busy", busy, 0);
        rst = 1'b0;
        #(BIT_NS / 2);
        uart_rx = 1'b0;
        #(2 * BIT_NS);
        uart_rx = 1'b1;
        #(2 * BIT_NS);
        idle(20);
        chk("midrst_no_valid", vq_cyc.size() - v0, 0);
        chk("midrst_no_ferr", ferr_cnt - f0, 0);
        align();
        send_byte(8'h7E, BIT_NS, 1'b1);
        idle(20);
        chk("midrst_next_count", vq_cyc.size() - v0, 1);
        if (vq_cyc.size() == v0 + 1) chk("midrst_next_data", vq_data[v0], 8'h7E);

        // Baud tolerance: 15.5 and 16.5 clocks per bit
        v0 = vq_cyc.size();
        align();
        send_byte(8'h3C, 155, 1'b1);
        idle(20);
        chk("fast_count", vq_cyc.size() - v0, 1);
        if (vq_cyc.size() == v0 + 1) chk("fast_data", vq_data[v0], 8'h3C);
        v0 = vq_cyc.size();
        align();
        send_byte(8'h3C, 165, 1'b1);
        idle(20);
        chk("slow_count", vq_cyc.size() - v0, 1);
        if (vq_cyc.size() == v0 + 1) chk("slow_data", vq_data[v0], 8'h3C);

        chk("never_both", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_uart_rx_fsm
